// File: rtl/vga_timing_pkg.sv
// Timing constants and coordinate type shared by the 640x480@60 Hz raster generator.
package vga_timing_pkg;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int H_TOTAL  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
   localparam int HS_START = H_VISIBLE_DEF + H_FRONT_DEF;
   localparam int HS_END   = HS_START + H_SYNC_DEF - 1;
   localparam int VS_START = V_VISIBLE_DEF + V_FRONT_DEF;
   localparam int VS_END   = VS_START + V_SYNC_DEF - 1;

   typedef logic [9:0] pix_coord_t;

endpackage

// File: rtl/vga_sync_dly.sv
// Shift register that delays {hsync, vsync} to line up with the colour stage output.
module vga_sync_dly #(
   parameter int STAGES = 3
) (
   input  logic       clk_25m,
   input  logic       rst_n,
   input  logic [1:0] sync_p0,
   output logic [1:0] sync_dly
);

   generate
      if (STAGES == 0) begin : g_bypass
         assign sync_dly = sync_p0;
      end else begin : g_shift
         logic [1:0] stage_q [STAGES];

         // Syncs are active-low, so idle (reset) level is 1 in every stage.
         always_ff @(posedge clk_25m or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < STAGES; i++) stage_q[i] <= 2'b11;
            end else begin
               stage_q[0] <= sync_p0;
               for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign sync_dly = stage_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster counters, active-area flag, delayed syncs and per-frame strobe/counter.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF,
   parameter int PIPE_DLY  = 3
) (
   input  logic        clk_25m,
   input  logic        rst_n,
   output pix_coord_t  hc,
   output pix_coord_t  vc,
   output logic        valid,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_tick,
   output logic [15:0] frame_cnt
);

   localparam pix_coord_t H_LAST   = pix_coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam pix_coord_t V_LAST   = pix_coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam pix_coord_t H_VIS    = pix_coord_t'(H_VISIBLE);
   localparam pix_coord_t V_VIS    = pix_coord_t'(V_VISIBLE);
   localparam pix_coord_t HS_FIRST = pix_coord_t'(H_VISIBLE + H_FRONT);
   localparam pix_coord_t HS_LAST  = pix_coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam pix_coord_t VS_FIRST = pix_coord_t'(V_VISIBLE + V_FRONT);
   localparam pix_coord_t VS_LAST  = pix_coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   pix_coord_t hc_nxt;
   pix_coord_t vc_nxt;
   logic       hs_p0;
   logic       vs_p0;
   logic [1:0] sync_dly;

   always_comb begin
      hc_nxt = hc + 10'd1;
      vc_nxt = vc;
      if (hc == H_LAST) begin
         hc_nxt = '0;
         vc_nxt = (vc == V_LAST) ? '0 : vc + 10'd1;
      end
   end

   // Stage p0: every registered output is decoded from next-state counters so it matches hc/vc.
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         hc         <= '0;
         vc         <= '0;
         valid      <= 1'b0;
         hs_p0      <= 1'b1;
         vs_p0      <= 1'b1;
         frame_tick <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         hc         <= hc_nxt;
         vc         <= vc_nxt;
         valid      <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
         hs_p0      <= !((hc_nxt >= HS_FIRST) && (hc_nxt <= HS_LAST));
         vs_p0      <= !((vc_nxt >= VS_FIRST) && (vc_nxt <= VS_LAST));
         frame_tick <= (hc_nxt == '0) && (vc_nxt == V_VIS);
         if ((hc_nxt == '0) && (vc_nxt == V_VIS)) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Stages p1..pN: align syncs with the colour stage's registered pixel.
   vga_sync_dly #(
      .STAGES (PIPE_DLY)
   ) u_sync_dly (
      .clk_25m  (clk_25m),
      .rst_n    (rst_n),
      .sync_p0  ({hs_p0, vs_p0}),
      .sync_dly (sync_dly)
   );

   assign hsync = sync_dly[1];
   assign vsync = sync_dly[0];

endmodule
